// File: rtl/z80_trace_pkg.sv
// z80_trace_pkg: shared types for the Z80 bus tracer.
//   kind_e        - 3-bit bus cycle classification (FETCH, MRD, MWR, IORD, IOWR, INTACK)
//   KIND_*        - the same encodings as named constants
//   state_e       - classifier FSM states
//   trace_entry_t - {kind, addr, data} as stored in the trace FIFO
// Optional feature macro: Z80_TRACE_TIMESTAMP_EN (the timestamp is appended by the top level).
package z80_trace_pkg;

   typedef enum logic [2:0] {
      KindFetch  = 3'd0,
      KindMrd    = 3'd1,
      KindMwr    = 3'd2,
      KindIord   = 3'd3,
      KindIowr   = 3'd4,
      KindIntack = 3'd5
   } kind_e;

   localparam kind_e KIND_FETCH  = KindFetch;
   localparam kind_e KIND_MRD    = KindMrd;
   localparam kind_e KIND_MWR    = KindMwr;
   localparam kind_e KIND_IORD   = KindIord;
   localparam kind_e KIND_IOWR   = KindIowr;
   localparam kind_e KIND_INTACK = KindIntack;

   typedef enum logic {StIdle, StActive} state_e;

   // The timestamp width is a top-level parameter, so it is not part of this struct.
   typedef struct packed {
      kind_e       kind;
      logic [15:0] addr;
      logic [7:0]  data;
   } trace_entry_t;

   localparam int unsigned ENTRY_W = $bits(trace_entry_t);

   function automatic logic kind_is_write(kind_e k);
      return (k == KindMwr) || (k == KindIowr);
   endfunction

endpackage

// File: rtl/z80_bus_tracer_if.sv
// z80_bus_tracer_if: CPU bus strobes/address/data observed by the tracer, plus the trace
// read-out handshake.
//   master - the CPU/bench side: drives the bus and tr_ready, reads the trace head
//   slave  - the tracer: observes the bus, presents tr_valid/tr_kind/tr_addr/tr_data/tr_ts
// Parameter TS_W sizes tr_ts (only meaningful with Z80_TRACE_TIMESTAMP_EN).
interface z80_bus_tracer_if #(
   parameter int unsigned TS_W = 16
);
   logic            m1_n;
   logic            mreq_n;
   logic            iorq_n;
   logic            rd_n;
   logic            wr_n;
   logic            rfsh_n;
   logic [15:0]     A;
   logic [7:0]      di;
   logic [7:0]      dout;
   logic            tr_valid;
   logic            tr_ready;
   logic [2:0]      tr_kind;
   logic [15:0]     tr_addr;
   logic [7:0]      tr_data;
   logic [TS_W-1:0] tr_ts;

   modport master (
      output m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, A, di, dout, tr_ready,
      input  tr_valid, tr_kind, tr_addr, tr_data, tr_ts
   );

   modport slave (
      input  m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, A, di, dout, tr_ready,
      output tr_valid, tr_kind, tr_addr, tr_data, tr_ts
   );
endinterface

// File: rtl/z80_trace_fifo.sv
// z80_trace_fifo: generic synchronous FIFO with clock enable.
//   clk, reset  - clock, synchronous active-high reset (flushes, clears held output)
//   en          - clock enable; nothing changes when 0
//   push, wdata - write request; accepted when not full, or when full and a pop happens too
//   pop         - read request; ignored when empty
//   rdata       - head entry, or the last popped entry while empty (0 after reset)
//   full, empty - occupancy flags
// Parameters: DEPTH (power of two, >= 2), WIDTH (entry bits).
module z80_trace_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 27
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic [WIDTH-1:0] last_q;
   logic             do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_W'(DEPTH));
   assign do_pop  = en & pop & ~empty;
   assign do_push = en & push & (~full | do_pop);
   assign rdata   = empty ? last_q : mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         last_q   <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            last_q   <= mem_q[rd_ptr_q];
         end
         if (do_push && !do_pop) begin
            count_q <= count_q + CNT_W'(1);
         end else if (do_pop && !do_push) begin
            count_q <= count_q - CNT_W'(1);
         end
      end
   end
endmodule

// File: rtl/z80_bus_tracer.sv
// z80_bus_tracer: passive tv80s bus observer. Classifies each completed bus cycle and queues
// {kind, addr, data[, ts]} in a trace FIFO.
//   clk, reset - CPU clock, synchronous active-high reset
//   cen        - CPU clock enable; all state holds when 0
//   bus        - z80_bus_tracer_if.slave: CPU strobes, A, di, dout in; trace head + tr_ready
//   overflow   - sticky: an entry was dropped because the FIFO was full
//   m1_count   - completed FETCH cycles (wraps)
// Parameters: DEPTH (FIFO entries, power of two >= 2), TS_W (timestamp width).
// Optional feature: define Z80_TRACE_TIMESTAMP_EN to stamp each entry with the free-running
// cen-cycle count at the start of its bus cycle; otherwise tr_ts is tied to 0.
module z80_bus_tracer
   import z80_trace_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned TS_W  = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cen,
   z80_bus_tracer_if.slave bus,
   output logic            overflow,
   output logic [15:0]     m1_count
);
`ifdef Z80_TRACE_TIMESTAMP_EN
   localparam int unsigned FIFO_W = ENTRY_W + TS_W;
   logic [TS_W-1:0] ts_q, ts_start_q, ts_start_d;
`else
   localparam int unsigned FIFO_W = ENTRY_W;
`endif

   logic         mem_act, io_act, cyc_act;
   kind_e        cyc_kind;
   state_e       state_q, state_d;
   kind_e        kind_q, kind_d;
   logic [15:0]  addr_q, addr_d;
   logic [7:0]   data_q, data_d;
   logic         block_q;
   logic         push, pop_fire;
   logic         fifo_full, fifo_empty;
   trace_entry_t push_entry, head_entry;
   logic [FIFO_W-1:0] fifo_wdata, fifo_rdata;

   // Bus decode: refresh and unqualified strobes are not cycles.
   always_comb begin
      mem_act = ~bus.mreq_n & (~bus.rd_n | ~bus.wr_n) & bus.rfsh_n;
      io_act  = ~bus.iorq_n & (~bus.rd_n | ~bus.wr_n | ~bus.m1_n);
      cyc_act = mem_act | io_act;
      if (!bus.m1_n && !bus.iorq_n) begin
         cyc_kind = KindIntack;
      end else if (mem_act) begin
         cyc_kind = !bus.m1_n ? KindFetch : (!bus.wr_n ? KindMwr : KindMrd);
      end else begin
         cyc_kind = !bus.wr_n ? KindIowr : KindIord;
      end
   end

   always_comb begin
      state_d = state_q;
      kind_d  = kind_q;
      addr_d  = addr_q;
      data_d  = data_q;
      push    = 1'b0;
`ifdef Z80_TRACE_TIMESTAMP_EN
      ts_start_d = ts_start_q;
`endif
      if (cen) begin
         unique case (state_q)
            StIdle: begin
               // block_q: a cycle already running when reset was released is ignored.
               if (cyc_act && !block_q) begin
                  state_d = StActive;
                  kind_d  = cyc_kind;
                  addr_d  = bus.A;
                  data_d  = kind_is_write(cyc_kind) ? bus.dout : bus.di;
`ifdef Z80_TRACE_TIMESTAMP_EN
                  ts_start_d = ts_q;
`endif
               end
            end
            StActive: begin
               if (cyc_act) begin
                  addr_d = bus.A;
                  data_d = kind_is_write(kind_q) ? bus.dout : bus.di;
               end else begin
                  state_d = StIdle;
                  push    = 1'b1;
               end
            end
         endcase
      end
   end

   assign pop_fire = cen & bus.tr_ready & ~fifo_empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         kind_q   <= KindFetch;
         addr_q   <= '0;
         data_q   <= '0;
         block_q  <= 1'b1;
         overflow <= 1'b0;
         m1_count <= '0;
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         if (cen && !cyc_act) begin
            block_q <= 1'b0;
         end
         if (push && fifo_full && !pop_fire) begin
            overflow <= 1'b1;
         end
         // Counted even when the entry itself is dropped.
         if (push && (kind_q == KindFetch)) begin
            m1_count <= m1_count + 16'd1;
         end
      end
   end

`ifdef Z80_TRACE_TIMESTAMP_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         ts_q       <= '0;
         ts_start_q <= '0;
      end else if (cen) begin
         ts_q       <= ts_q + TS_W'(1);
         ts_start_q <= ts_start_d;
      end
   end
`endif

   always_comb begin
      push_entry.kind = kind_q;
      push_entry.addr = addr_q;
      push_entry.data = data_q;
   end

`ifdef Z80_TRACE_TIMESTAMP_EN
   assign fifo_wdata = {ts_start_q, push_entry};
   assign bus.tr_ts  = fifo_rdata[FIFO_W-1:ENTRY_W];
`else
   assign fifo_wdata = push_entry;
   assign bus.tr_ts  = '0;
`endif

   z80_trace_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (FIFO_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .en    (cen),
      .push  (push),
      .wdata (fifo_wdata),
      .pop   (bus.tr_ready),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign head_entry   = trace_entry_t'(fifo_rdata[ENTRY_W-1:0]);
   assign bus.tr_valid = ~fifo_empty;
   assign bus.tr_kind  = head_entry.kind;
   assign bus.tr_addr  = head_entry.addr;
   assign bus.tr_data  = head_entry.data;
endmodule

// File: tb/tb_z80_bus_tracer.sv
// Bench for z80_bus_tracer (DEPTH=4). Bus cycles are generated as whole transactions; a
// queue-based model records what each completed cycle should leave in the trace.
module tb_z80_bus_tracer;
   import z80_trace_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned TS_W  = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        cen;
   logic        overflow;
   logic [15:0] m1_count;

   z80_bus_tracer_if #(.TS_W(TS_W)) bus ();

   z80_bus_tracer #(
      .DEPTH (DEPTH),
      .TS_W  (TS_W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .cen      (cen),
      .bus      (bus),
      .overflow (overflow),
      .m1_count (m1_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]      kind;
      logic [15:0]     addr;
      logic [7:0]      data;
      logic [TS_W-1:0] ts;
   } entry_t;

   entry_t          exp_q[$];
   entry_t          last_pop;
   entry_t          cur;
   bit              in_cyc;
   bit              blocked;
   bit              exp_ovf;
   logic [15:0]     exp_m1;
   logic [TS_W-1:0] ts_cnt;

   bit          drv_act;
   logic [2:0]  drv_kind;
   logic [15:0] drv_addr;
   logic [7:0]  drv_data;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [2:0] k, input logic [15:0] a,
                                      input logic [7:0] d);
      return {5'd0, k, a, d};
   endfunction

   function automatic logic [31:0] head_word();
      return {5'd0, bus.tr_kind, bus.tr_addr, bus.tr_data};
   endfunction

   function automatic bit pick_rdy(input int mode);
      if (mode == 0) return 1'b0;
      if (mode == 1) return 1'b1;
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic model_reset();
      exp_q.delete();
      last_pop.kind = '0;
      last_pop.addr = '0;
      last_pop.data = '0;
      last_pop.ts   = '0;
      cur     = last_pop;
      in_cyc  = 1'b0;
      blocked = 1'b1;
      exp_ovf = 1'b0;
      exp_m1  = '0;
      ts_cnt  = '0;
   endtask

   // Pin patterns for each kind, straight from the Z80 strobe conventions.
   task automatic drive_cycle(input logic [2:0] k, input logic [15:0] a, input logic [7:0] d);
      bit wr;
      wr          = (k == KIND_MWR) || (k == KIND_IOWR);
      drv_act     = 1'b1;
      drv_kind    = k;
      drv_addr    = a;
      drv_data    = d;
      bus.m1_n    = !((k == KIND_FETCH) || (k == KIND_INTACK));
      bus.mreq_n  = !((k == KIND_FETCH) || (k == KIND_MRD) || (k == KIND_MWR));
      bus.iorq_n  = !((k == KIND_IORD) || (k == KIND_IOWR) || (k == KIND_INTACK));
      bus.rd_n    = !((k == KIND_FETCH) || (k == KIND_MRD) || (k == KIND_IORD));
      bus.wr_n    = !wr;
      bus.rfsh_n  = 1'b1;
      bus.A       = a;
      bus.dout    = wr ? d : 8'($urandom);
      bus.di      = wr ? 8'($urandom) : d;
   endtask

   // 0 quiet, 1 refresh, 2 bare MREQ, 3 bare IORQ; negative picks one at random.
   task automatic drive_idle(input int pat);
      int p;
      p = (pat < 0) ? int'($urandom_range(0, 3)) : pat;
      drv_act    = 1'b0;
      bus.m1_n   = 1'b1;
      bus.mreq_n = !((p == 1) || (p == 2));
      bus.iorq_n = !(p == 3);
      bus.rd_n   = 1'b1;
      bus.wr_n   = 1'b1;
      bus.rfsh_n = !(p == 1);
      bus.A      = 16'($urandom);
      bus.di     = 8'($urandom);
      bus.dout   = 8'($urandom);
   endtask

   task automatic compare_outputs();
      entry_t h;
      bit     v;
      v = (exp_q.size() != 0);
      h = v ? exp_q[0] : last_pop;
      check("valid", 32'(bus.tr_valid), 32'(v));
      check("kind", 32'(bus.tr_kind), 32'(h.kind));
      check("addr", 32'(bus.tr_addr), 32'(h.addr));
      check("data", 32'(bus.tr_data), 32'(h.data));
`ifdef Z80_TRACE_TIMESTAMP_EN
      check("ts", 32'(bus.tr_ts), 32'(h.ts));
`else
      check("ts", 32'(bus.tr_ts), 32'd0);
`endif
      check("overflow", 32'(overflow), 32'(exp_ovf));
      check("m1_count", 32'(m1_count), 32'(exp_m1));
   endtask

   // One clock: apply cen/tr_ready, advance the model, then compare on the falling edge.
   task automatic step(input bit c, input bit rdy);
      cen          = c;
      bus.tr_ready = rdy;
      if (reset) begin
         model_reset();
      end else if (c) begin
         if (rdy && exp_q.size() > 0) begin
            last_pop = exp_q.pop_front();
         end
         if (in_cyc && !drv_act) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(cur);
            else exp_ovf = 1'b1;
            if (cur.kind == KIND_FETCH) exp_m1++;
            in_cyc = 1'b0;
         end else if (drv_act && !blocked) begin
            if (!in_cyc) begin
               in_cyc   = 1'b1;
               cur.kind = drv_kind;
               cur.ts   = ts_cnt;
            end
            cur.addr = drv_addr;
            cur.data = drv_data;
         end
         if (!drv_act) blocked = 1'b0;
         ts_cnt++;
      end
      @(posedge clk);
      @(negedge clk);
      compare_outputs();
   endtask

   // A bus cycle lasting n enabled clocks (only the last carries the final addr/data),
   // followed by an idle gap of one enabled clock.
   task automatic run_cycle(input logic [2:0] k, input logic [15:0] a, input logic [7:0] d,
                            input int n, input int act_rmode, input int gap_rmode,
                            input bit rcen, input int gap_pat);
      int done;
      bit c;
      done = 0;
      while (done < n) begin
         if (done == n - 1) drive_cycle(k, a, d);
         else drive_cycle(k, 16'($urandom), 8'($urandom));
         c = rcen ? ($urandom_range(0, 3) != 0) : 1'b1;
         step(c, pick_rdy(act_rmode));
         if (c) done++;
      end
      drive_idle(gap_pat);
      c = 1'b0;
      while (!c) begin
         c = rcen ? ($urandom_range(0, 3) != 0) : 1'b1;
         step(c, pick_rdy(gap_rmode));
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive_idle(0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      reset = 1'b0;
      step(1'b1, 1'b0);
   endtask

   task automatic pop_one();
      drive_idle(0);
      step(1'b1, 1'b1);
   endtask

   initial begin
      int pops;
      reset = 1'b1;
      cen   = 1'b0;
      bus.tr_ready = 1'b0;
      drive_idle(0);
      model_reset();

      // Reset state
      do_reset();
      check("rst_valid", 32'(bus.tr_valid), 32'd0);
      check("rst_head", head_word(), 32'd0);
      check("rst_m1", 32'(m1_count), 32'd0);

      // CB 67: two fetches, refresh in between is not recorded
      run_cycle(KIND_FETCH, 16'h0000, 8'hCB, 2, 0, 0, 1'b0, 1);
      run_cycle(KIND_FETCH, 16'h0001, 8'h67, 2, 0, 0, 1'b0, 1);
      drive_idle(1);
      step(1'b1, 1'b0);
      check("cb_m1", 32'(m1_count), 32'd2);
      check("cb_first", head_word(), mk(KIND_FETCH, 16'h0000, 8'hCB));
      pop_one();
      check("cb_second", head_word(), mk(KIND_FETCH, 16'h0001, 8'h67));
      pop_one();
      check("cb_empty", 32'(bus.tr_valid), 32'd0);
      check("cb_hold", head_word(), mk(KIND_FETCH, 16'h0001, 8'h67));

      // LD (HL),A with HL=394D, A=10
      do_reset();
      run_cycle(KIND_FETCH, 16'h0000, 8'h77, 2, 0, 0, 1'b0, 1);
      run_cycle(KIND_MWR, 16'h394D, 8'h10, 3, 0, 0, 1'b0, 0);
      check("ld_fetch", head_word(), mk(KIND_FETCH, 16'h0000, 8'h77));
      pop_one();
      check("ld_write", head_word(), mk(KIND_MWR, 16'h394D, 8'h10));

      // OUT (20h),A with A=5A; IN A,(21h) returning 3C
      do_reset();
      run_cycle(KIND_IOWR, 16'h5A20, 8'h5A, 3, 0, 0, 1'b0, 0);
      run_cycle(KIND_IORD, 16'h5A21, 8'h3C, 3, 0, 0, 1'b0, 0);
      check("out_entry", {8'd0, 5'(bus.tr_kind), bus.tr_addr[7:0], bus.tr_data},
            {8'd0, 5'(KIND_IOWR), 8'h20, 8'h5A});
      pop_one();
      check("in_entry", {8'd0, 5'(bus.tr_kind), bus.tr_addr[7:0], bus.tr_data},
            {8'd0, 5'(KIND_IORD), 8'h21, 8'h3C});

      // Six fetches into a 4-deep FIFO with nobody popping
      do_reset();
      for (int i = 0; i < 6; i++) begin
         run_cycle(KIND_FETCH, 16'h0100 + 16'(i), 8'h10 + 8'(i), 2, 0, 0, 1'b0, -1);
      end
      check("ovf_flag", 32'(overflow), 32'd1);
      check("ovf_m1", 32'(m1_count), 32'd6);
      for (int i = 0; i < 4; i++) begin
         check("ovf_order", head_word(), mk(KIND_FETCH, 16'h0100 + 16'(i), 8'h10 + 8'(i)));
         pop_one();
      end
      check("ovf_lost", 32'(bus.tr_valid), 32'd0);

      // Full FIFO, pop in the same clock as the push
      do_reset();
      for (int i = 0; i < 5; i++) begin
         run_cycle(KIND_FETCH, 16'h0200 + 16'(i), 8'h20 + 8'(i), 2, 0, (i == 4) ? 1 : 0,
                   1'b0, 0);
      end
      check("fullpop_ovf", 32'(overflow), 32'd0);
      for (int i = 1; i < 5; i++) begin
         check("fullpop_order", head_word(), mk(KIND_FETCH, 16'h0200 + 16'(i), 8'h20 + 8'(i)));
         pop_one();
      end
      check("fullpop_empty", 32'(bus.tr_valid), 32'd0);

      // Randomized traffic with cen gaps and random consumer
      do_reset();
      for (int i = 0; i < 400; i++) begin
         run_cycle(3'($urandom_range(0, 5)), 16'($urandom), 8'($urandom),
                   int'($urandom_range(1, 4)), 2, 2, 1'b1, -1);
         if ($urandom_range(0, 3) == 0) begin
            drive_idle(-1);
            for (int j = 0; j < int'($urandom_range(1, 4)); j++) begin
               step(1'($urandom_range(0, 1)), pick_rdy(2));
            end
         end
      end

      // Reset mid-MRD with cen toggling; the interrupted cycle must vanish
      drive_cycle(KIND_MRD, 16'h4321, 8'h99);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      reset = 1'b1;
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      reset = 1'b0;
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      drive_idle(0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      check("rstmid_valid", 32'(bus.tr_valid), 32'd0);
      check("rstmid_m1", 32'(m1_count), 32'd0);
      check("rstmid_ovf", 32'(overflow), 32'd0);
      run_cycle(KIND_FETCH, 16'h0042, 8'hED, 2, 0, 0, 1'b1, 0);
      check("rstmid_next", head_word(), mk(KIND_FETCH, 16'h0042, 8'hED));

      // Drain, bounded
      drive_idle(0);
      pops = 0;
      for (int i = 0; i < 3 * DEPTH + 8; i++) begin
         if (bus.tr_valid) begin
            step(1'b1, 1'b1);
            pops++;
         end
      end
      check("drain_count", 32'(pops), 32'd1);
      check("drain_done", 32'(bus.tr_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
